// File: rtl/regfile_pkg.sv
// Shared constants and types for the self-clearing MIPS-style register file.
package regfile_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int ADDR_BITS_DEF = 5;
    localparam int NREGS         = 2 ** ADDR_BITS_DEF;
    localparam int ZERO_REG      = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks registers 1..NREGS-1 writing zero, then admits user writes.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_req_i,
    input  logic                 user_we_i,
    output logic                 busy_o,
    output logic                 clr_we_o,
    output logic [ADDR_BITS-1:0] clr_addr_o,
    output logic                 write_dropped_o
);

    localparam logic [ADDR_BITS-1:0] FIRST_IDX = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'((2 ** ADDR_BITS) - 1);

    state_e               state_q;
    logic [ADDR_BITS-1:0] clr_idx_q;
    logic                 write_dropped_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= CLEAR;
            clr_idx_q       <= FIRST_IDX;
            write_dropped_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    write_dropped_q <= user_we_i;
                    clr_idx_q       <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    write_dropped_q <= 1'b0;
                    if (clear_req_i) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= FIRST_IDX;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    // Holding reset must not disturb storage, so the clear write waits for release.
    assign busy_o          = (state_q == CLEAR);
    assign clr_we_o        = (state_q == CLEAR) && !rst_i;
    assign clr_addr_o      = clr_idx_q;
    assign write_dropped_o = write_dropped_q;

endmodule : regfile_clr_seq

// File: rtl/regfile_clr.sv
// 32x32 register file: two combinational reads, one write, r0 = 0, write-through bypass.
module regfile_clr
    import regfile_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 ClearReq,
    output logic                 Busy,
    output logic                 WriteDropped
);

    localparam int                   DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(ZERO_REG);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic                 user_we;
    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_addr;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;

    assign user_we = RegWrite && (WriteRegister != ZERO_ADDR);

    regfile_clr_seq #(
        .ADDR_BITS(ADDR_BITS)
    ) u_seq (
        .clk_i          (Clk),
        .rst_i          (Reset),
        .clear_req_i    (ClearReq),
        .user_we_i      (user_we),
        .busy_o         (Busy),
        .clr_we_o       (clr_we),
        .clr_addr_o     (clr_addr),
        .write_dropped_o(WriteDropped)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we = 1'b1;
        end else if (user_we && !Busy) begin
            mem_we    = 1'b1;
            mem_waddr = WriteRegister;
            mem_wdata = WriteData;
        end
    end

    // NOTE: storage has no reset so it can map onto RAM; the clear sequencer
    // zeroes it instead, and reads are masked until that finishes.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (!Busy) begin
            if (ReadRegister1 != ZERO_ADDR) begin
                if (BYPASS && user_we && (ReadRegister1 == WriteRegister)) begin
                    ReadData1 = WriteData;
                end else begin
                    ReadData1 = mem[ReadRegister1];
                end
            end
            if (ReadRegister2 != ZERO_ADDR) begin
                if (BYPASS && user_we && (ReadRegister2 == WriteRegister)) begin
                    ReadData2 = WriteData;
                end else begin
                    ReadData2 = mem[ReadRegister2];
                end
            end
        end
    end

endmodule : regfile_clr

// File: tb/tb_regfile_clr.sv
// Scoreboard bench for regfile_clr: reference model pushes expectations, monitor checks at negedge.
module tb_regfile_clr;

    localparam int W  = 32;
    localparam int AB = 5;
    localparam int N  = 32;

    logic          Clk;
    logic          Reset;
    logic [AB-1:0] ReadRegister1, ReadRegister2, WriteRegister;
    logic [W-1:0]  ReadData1, ReadData2, WriteData;
    logic          RegWrite, ClearReq, Busy, WriteDropped;

    regfile_clr #(.WIDTH(W), .ADDR_BITS(AB), .BYPASS(1'b1)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .ClearReq     (ClearReq),
        .Busy         (Busy),
        .WriteDropped (WriteDropped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string        tag;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic         busy;
        logic         drop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents plus a count of clear edges remaining.
    logic [W-1:0] m_mem [N];
    bit           m_busy;
    int           m_left;
    bit           m_drop;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_left = N - 1;
        m_drop = 1'b0;
    endtask

    function automatic logic [W-1:0] model_read(input int a, input bit we, input int wa, input logic [W-1:0] wd);
        if (m_busy || a == 0) return '0;
        if (we && wa != 0 && a == wa) return wd;
        return m_mem[a];
    endfunction

    task automatic model_edge(input bit we, input int wa, input logic [W-1:0] wd, input bit clr);
        bit drop_n;
        drop_n = m_busy && we && (wa != 0);
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                for (int i = 1; i < N; i++) m_mem[i] = '0;
            end
        end else begin
            if (we && wa != 0) m_mem[wa] = wd;
            if (clr) begin
                m_busy = 1'b1;
                m_left = N - 1;
            end
        end
        m_drop = drop_n;
    endtask

    // One clock cycle: drive just after a rising edge, queue the expectation, advance the model.
    task automatic cycle(input string tag, input bit rst, input int ra1, input int ra2,
                         input bit we, input int wa, input logic [W-1:0] wd, input bit clr);
        exp_t e;
        Reset         = rst;
        ReadRegister1 = AB'(ra1);
        ReadRegister2 = AB'(ra2);
        RegWrite      = we;
        WriteRegister = AB'(wa);
        WriteData     = wd;
        ClearReq      = clr;
        if (rst) model_reset();
        e.tag  = tag;
        e.rd1  = model_read(ra1, we, wa, wd);
        e.rd2  = model_read(ra2, we, wa, wd);
        e.busy = m_busy;
        e.drop = m_drop;
        sb.push_back(e);
        @(posedge Clk);
        if (!rst) model_edge(we, wa, wd, clr);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, (i % (N - 1)) + 1, (i * 7) % N, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 1; i < N; i++) cycle(tag, 1'b0, i, N - i, 1'b0, 0, '0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".rd1"},  ReadData1, e.rd1);
                check({e.tag, ".rd2"},  ReadData2, e.rd2);
                check({e.tag, ".busy"}, W'(Busy), W'(e.busy));
                check({e.tag, ".drop"}, W'(WriteDropped), W'(e.drop));
            end
        end
    end

    initial begin : stimulus
        int busy_edges;
        int budget;
        Reset = 1'b1;
        ReadRegister1 = '0; ReadRegister2 = '0; WriteRegister = '0;
        WriteData = '0; RegWrite = 1'b0; ClearReq = 1'b0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        model_reset();
        @(posedge Clk); #1;

        cycle("reset", 1'b1, 3, 4, 1'b0, 0, '0, 1'b0);
        cycle("reset", 1'b1, 5, 6, 1'b1, 5, 32'd77, 1'b0);
        idle("clear0", N - 1);
        read_all("post_clear0");

        cycle("wr42",   1'b0, 2, 2, 1'b1, 2, 32'd42, 1'b0);
        cycle("rd42",   1'b0, 2, 2, 1'b0, 2, 32'd300, 1'b0);
        cycle("onehot", 1'b0, 1, 21, 1'b0, 0, '0, 1'b0);
        cycle("wr_r0",  1'b0, 0, 2, 1'b1, 0, 32'd7234, 1'b0);
        cycle("rd_r0",  1'b0, 0, 0, 1'b0, 0, '0, 1'b0);
        cycle("wr2000", 1'b0, 2, 1, 1'b1, 2, 32'd2000, 1'b0);
        cycle("wr17k",  1'b0, 3, 4, 1'b1, 17, 32'd17000, 1'b0);
        cycle("rd17_2", 1'b0, 17, 2, 1'b0, 0, '0, 1'b0);
        cycle("byp555", 1'b0, 5, 17, 1'b1, 5, 32'd555, 1'b0);
        cycle("rd555",  1'b0, 5, 2, 1'b0, 0, '0, 1'b0);

        cycle("clr_wr99", 1'b0, 9, 5, 1'b1, 9, 32'd99, 1'b1);
        idle("clear1a", 5);
        cycle("drop123", 1'b0, 3, 9, 1'b1, 3, 32'd123, 1'b0);
        cycle("drop_pulse", 1'b0, 3, 9, 1'b0, 0, '0, 1'b1);
        idle("clear1b", N - 1 - 7);
        cycle("after1", 1'b0, 9, 3, 1'b0, 0, '0, 1'b0);
        read_all("post_clear1");

        // Explicit edge count of Busy during a fresh clear, bounded.
        cycle("clr2_start", 1'b0, 1, 2, 1'b1, 7, 32'd7, 1'b1);
        busy_edges = 1;
        budget = 0;
        while (m_busy && budget < 100) begin
            cycle("clear2", 1'b0, 7, 0, 1'b0, 0, '0, 1'b0);
            if (m_busy) busy_edges++;
            budget++;
        end
        check("clear_edges", W'(busy_edges), W'(N - 1));

        cycle("clr3_start", 1'b0, 1, 2, 1'b1, 4, 32'd4444, 1'b1);
        idle("clear3", 9);
        cycle("rst_mid", 1'b1, 4, 1, 1'b0, 0, '0, 1'b0);
        cycle("rst_mid", 1'b1, 4, 1, 1'b1, 4, 32'd1, 1'b0);
        idle("clear4", N - 1);
        read_all("post_clear4");

        for (int i = 0; i < 500; i++) begin
            cycle("rand", ($urandom_range(0, 299) == 0), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                  $urandom_range(0, 2) != 0, $urandom_range(0, N - 1), $urandom(),
                  $urandom_range(0, 59) == 0);
        end
        read_all("final");

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge Clk);
            budget++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_clr
